sram_march_bist: RTL and testbench
==================================

// Module: sram_march_bist
// PURPOSE
//   Built-in self-test engine sitting directly upstream of the 64x64 SRAM.
//   On start, drives the SRAM we/addr/din ports through a March C- sequence,
//   checks the registered read data, and reports pass/fail plus first-failure
//   diagnostics. Muxing between BIST and functional traffic is done outside.
// PARAMETERS
//   DATA_W   64   SRAM word width; backgrounds are all-0s / all-1s of this width
//   ADDR_W   6    SRAM address width; N = 2**ADDR_W locations
//   ERR_W    8    width of saturating error counter
// PORTS
//   clk            in   1       rising-edge clock, same clock as SRAM
//   rst            in   1       asynchronous, active-high reset
//   start          in   1       pulse/level; accepted only in IDLE
//   busy           out  1       high from accepted start until done
//   done           out  1       one-cycle pulse at end of run
//   pass           out  1       valid when done; held until next accepted start
//   err_cnt        out  ERR_W   number of mismatching reads, saturates at all-1s
//   fail_addr      out  ADDR_W  address of first mismatch
//   fail_elem      out  3       March element index (0..5) of first mismatch
//   fail_syndrome  out  DATA_W  dout XOR expected at first mismatch
//   mem_we         out  1       to SRAM we
//   mem_addr       out  ADDR_W  to SRAM addr
//   mem_din        out  DATA_W  to SRAM din
//   mem_dout       in   DATA_W  from SRAM dout (1-cycle registered read)
// BEHAVIOUR
//   - Reset (async, any time incl. mid-run): all outputs 0, FSM -> IDLE,
//     pending compare discarded. pass=0 after reset until a run completes.
//   - SRAM contract: read of addr A issued with mem_we=0 in cycle t; data
//     valid on mem_dout in cycle t+1. BIST compares in cycle t+1 only.
//   - March C- elements (E = element index, ^ up 0..N-1, v down N-1..0):
//     E0 ^(w0); E1 ^(r0,w1); E2 ^(r1,w0); E3 v(r0,w1); E4 v(r1,w0); E5 ^(r0).
//   - States: IDLE, E0_W, RD, WR (E1-E4, alternating per address), E5_RD,
//     FLUSH (final compare), DONE.
//   - IDLE: mem_we=0, mem_addr/mem_din=0. start=1 at edge T -> E0_W; clears
//     err_cnt, fail_*, pass; busy=1 from T+1.
//   - E0_W: one write per cycle, mem_din=0, addr ascending; after N-1 -> E1.
//   - E1-E4: per address RD cycle (mem_we=0) then WR cycle (mem_we=1, data =
//     element write value); read data of RD compared during WR cycle.
//     Address steps after WR; at last address of element go to next element,
//     resetting addr to 0 (up) or N-1 (down). No idle cycles between elements.
//   - E5_RD: one read per cycle ascending, compares pipelined one cycle
//     behind; after addr N-1 -> FLUSH (compare of addr N-1, mem_we=0) -> DONE.
//   - Run length: N + 8N + N + 1 = 10N+1 busy cycles (641 for N=64).
//   - DONE: done=1 for one cycle, busy=0, pass=(err_cnt==0), -> IDLE.
//   - Mismatch: err_cnt+1 (saturating); if first mismatch of run, capture
//     fail_addr/fail_elem/fail_syndrome; later mismatches do not overwrite.
//   - Run continues to completion after failures (no early abort).
//   - start while busy ignored; start held high in DONE cycle starts no run;
//     held high into IDLE starts a new run on the next edge.
//   - Address counter wraps only by explicit reload at element boundaries;
//     it never increments past N-1 or decrements below 0.
//   - Outputs to SRAM are registered (no combinational path start->mem_*).
// TESTING
//   1 Fault-free SRAM model, start pulse -> busy 641 cycles, done pulse,
//     pass=1, err_cnt=0, fail_* all 0.
//   2 Stuck-at-0 bit 5 at addr 17 -> pass=0, err_cnt=2, fail_addr=17,
//     fail_elem=2, fail_syndrome=64'h20.
//   3 Stuck-at-1 bit 0 at addr 63 -> pass=0, err_cnt=3, fail_addr=63,
//     fail_elem=1, fail_syndrome=64'h1.
//   4 Trace mem_addr/mem_we: E0 addr 0..63 we=1; E3 starts at addr 63 with
//     we=0 then we=1, ends addr 0; E5 only we=0.
//   5 rst asserted at cycle 200 of run -> all outputs 0 immediately; new start
//     afterwards yields full 641-cycle run and pass=1.
//   6 start re-pulsed at cycle 50 and held during DONE -> no restart mid-run,
//     single done pulse; second run begins only after return to IDLE.

Source files
------------

// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- built-in self-test engine for the 64x64 SRAM
//
// Drives the SRAM write-enable, address and write data through a March C-
// sequence, compares the registered read data one cycle after each read,
// and reports pass/fail with diagnostics for the first mismatch.
//
// Ports:
//   clk           rising-edge clock, shared with the SRAM
//   rst           asynchronous active-high reset
//   start         run request, accepted only in IDLE
//   busy          high for the whole run (10N+1 cycles)
//   done          one-cycle pulse at the end of a run
//   pass          run result, valid with done, held until the next accepted start
//   err_cnt       saturating count of mismatching reads
//   fail_addr     address of the first mismatch
//   fail_elem     March element index (0..5) of the first mismatch
//   fail_syndrome read data XOR expected data at the first mismatch
//   mem_we        SRAM write enable
//   mem_addr      SRAM address
//   mem_din       SRAM write data
//   mem_dout      SRAM read data, valid one cycle after the read is issued

module sram_march_bist #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_syndrome,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    E0_W  = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    E5_RD = 3'd4,
    FLUSH = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_MIN = {ADDR_W{1'b0}};
  localparam logic [ERR_W-1:0]  ERR_SAT  = {ERR_W{1'b1}};

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [2:0]        elem, elem_n;
  logic              we_n;
  logic [DATA_W-1:0] din_n;
  logic              start_acc;
  logic              elem_up;
  logic              elem_last;

  // Read pipeline: what was issued last cycle and what it should return.
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_elem;
  logic              rd_exp1;
  logic [DATA_W-1:0] syndrome;
  logic              mismatch;

  assign start_acc = (state == IDLE) && start;
  // E1/E2 walk upward, E3/E4 walk downward.
  assign elem_up   = (elem == 3'd1) || (elem == 3'd2);
  assign elem_last = elem_up ? (addr == ADDR_MAX) : (addr == ADDR_MIN);
  assign syndrome  = mem_dout ^ {DATA_W{rd_exp1}};
  assign mismatch  = rd_pend && (|syndrome);

  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign mem_addr = addr;

  always_comb begin
    state_n = state;
    addr_n  = addr;
    elem_n  = elem;
    case (state)
      IDLE: begin
        addr_n = ADDR_MIN;
        if (start) begin
          state_n = E0_W;
          elem_n  = 3'd0;
        end
      end
      E0_W: begin
        if (addr == ADDR_MAX) begin
          state_n = RD;
          elem_n  = 3'd1;
          addr_n  = ADDR_MIN;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      RD: begin
        state_n = WR;
      end
      WR: begin
        if (elem_last) begin
          if (elem == 3'd4) begin
            state_n = E5_RD;
            elem_n  = 3'd5;
            addr_n  = ADDR_MIN;
          end else begin
            state_n = RD;
            elem_n  = elem + 3'd1;
            // Next element is E2 (up) or E3/E4 (down).
            addr_n  = (elem == 3'd1) ? ADDR_MIN : ADDR_MAX;
          end
        end else begin
          state_n = RD;
          addr_n  = elem_up ? addr + 1'b1 : addr - 1'b1;
        end
      end
      E5_RD: begin
        if (addr == ADDR_MAX) begin
          state_n = FLUSH;
          addr_n  = ADDR_MIN;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      FLUSH: begin
        state_n = DONE;
        addr_n  = ADDR_MIN;
      end
      DONE: begin
        state_n = IDLE;
        addr_n  = ADDR_MIN;
      end
      default: begin
        state_n = IDLE;
        addr_n  = ADDR_MIN;
        elem_n  = 3'd0;
      end
    endcase

    // SRAM controls are computed for the upcoming state and registered.
    we_n  = (state_n == E0_W) || (state_n == WR);
    din_n = ((state_n == WR) && ((elem_n == 3'd1) || (elem_n == 3'd3)))
            ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= ADDR_MIN;
      elem    <= 3'd0;
      mem_we  <= 1'b0;
      mem_din <= '0;
      rd_pend <= 1'b0;
      rd_addr <= ADDR_MIN;
      rd_elem <= 3'd0;
      rd_exp1 <= 1'b0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      elem    <= elem_n;
      mem_we  <= we_n;
      mem_din <= din_n;
      rd_pend <= (state == RD) || (state == E5_RD);
      rd_addr <= addr;
      rd_elem <= elem;
      // E2 and E4 read back all-ones; every other read expects zeros.
      rd_exp1 <= (elem == 3'd2) || (elem == 3'd4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass          <= 1'b0;
      err_cnt       <= '0;
      fail_addr     <= '0;
      fail_elem     <= 3'd0;
      fail_syndrome <= '0;
    end else if (start_acc) begin
      pass          <= 1'b0;
      err_cnt       <= '0;
      fail_addr     <= '0;
      fail_elem     <= 3'd0;
      fail_syndrome <= '0;
    end else begin
      if (mismatch) begin
        if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 1'b1;
        // err_cnt is cleared per run and never wraps, so zero marks the first failure.
        if (err_cnt == '0) begin
          fail_addr     <= rd_addr;
          fail_elem     <= rd_elem;
          fail_syndrome <= syndrome;
        end
      end
      // FLUSH holds the last compare, so the verdict is settled here and valid in DONE.
      if (state == FLUSH) pass <= (err_cnt == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - self-checking bench for sram_march_bist
module tb_sram_march_bist;

  localparam int DW  = 64;
  localparam int AW  = 6;
  localparam int EW  = 8;
  localparam int N   = 64;
  localparam int RUN = 10 * N + 1;
  localparam int TMO = 2000;

  typedef struct {
    logic          pass;
    int            errs;
    int            faddr;
    int            felem;
    logic [DW-1:0] syn;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_syndrome;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int checks = 0;
  int failures = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  sram_march_bist #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_syndrome(fail_syndrome), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // SRAM model with one optional stuck-at fault location.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] m0, m1;
  int            fault_a;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    if (int'(mem_addr) == fault_a) mem_dout <= (mem[mem_addr] & ~m0) | m1;
    else                           mem_dout <= mem[mem_addr];
  end

  // Busy-cycle trace and done-pulse counter.
  int            bcnt, dcnt;
  logic          tr_we   [RUN + 8];
  logic [AW-1:0] tr_addr [RUN + 8];

  always @(negedge clk) begin
    if (busy) begin
      if (bcnt < RUN + 8) begin
        tr_we[bcnt]   = mem_we;
        tr_addr[bcnt] = mem_addr;
      end
      bcnt++;
    end
    if (done) dcnt++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < TMO) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, DW'(k < TMO), DW'(1));
  endtask

  task automatic wait_busy_cycles(input string tag, input int n);
    int k;
    k = 0;
    while (bcnt < n && k < TMO) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reach"}, DW'(k < TMO), DW'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input string tag, input exp_t e);
    exp_t g;
    sbq.push_back(e);
    bcnt = 0;
    dcnt = 0;
    pulse_start();
    wait_done(tag);
    g = sbq.pop_front();
    chk({tag, "_pass"},  DW'(pass),          DW'(g.pass));
    chk({tag, "_errs"},  DW'(err_cnt),       DW'(g.errs));
    chk({tag, "_faddr"}, DW'(fail_addr),     DW'(g.faddr));
    chk({tag, "_felem"}, DW'(fail_elem),     DW'(g.felem));
    chk({tag, "_syn"},   fail_syndrome,      g.syn);
    chk({tag, "_busy_len"}, DW'(bcnt),       DW'(RUN));
    @(negedge clk);
    chk({tag, "_done_cnt"}, DW'(dcnt),       DW'(1));
    chk({tag, "_idle_busy"}, DW'(busy),      DW'(0));
  endtask

  initial begin
    exp_t e;
    int   bad;

    rst = 1'b1;
    start = 1'b0;
    m0 = '0;
    m1 = '0;
    fault_a = -1;
    bcnt = 0;
    dcnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_pass", DW'(pass), DW'(0));
    chk("rst_we",   DW'(mem_we), DW'(0));
    chk("rst_addr", DW'(mem_addr), DW'(0));
    chk("rst_err",  DW'(err_cnt), DW'(0));
    rst = 1'b0;
    @(negedge clk);

    // Fault-free run.
    e = '{pass: 1'b1, errs: 0, faddr: 0, felem: 0, syn: '0};
    do_run("clean", e);

    // Address/we trace of the clean run.
    bad = 0;
    for (int i = 0; i < N; i++)
      if (tr_we[i] !== 1'b1 || tr_addr[i] !== AW'(i)) bad++;
    chk("trace_e0", DW'(bad), DW'(0));
    bad = 0;
    for (int j = 0; j < N; j++) begin
      if (tr_we[320 + 2*j] !== 1'b0 || tr_addr[320 + 2*j] !== AW'(N - 1 - j)) bad++;
      if (tr_we[321 + 2*j] !== 1'b1 || tr_addr[321 + 2*j] !== AW'(N - 1 - j)) bad++;
    end
    chk("trace_e3", DW'(bad), DW'(0));
    chk("trace_e3_first", DW'(tr_addr[320]), DW'(63));
    chk("trace_e3_last",  DW'(tr_addr[447]), DW'(0));
    bad = 0;
    for (int i = 0; i <= N; i++)
      if (tr_we[576 + i] !== 1'b0) bad++;
    for (int i = 0; i < N; i++)
      if (tr_addr[576 + i] !== AW'(i)) bad++;
    chk("trace_e5", DW'(bad), DW'(0));

    // Reset in the middle of a run after a passing run.
    bcnt = 0;
    pulse_start();
    wait_busy_cycles("midrst", 200);
    rst = 1'b1;
    #1;
    chk("midrst_busy", DW'(busy), DW'(0));
    chk("midrst_done", DW'(done), DW'(0));
    chk("midrst_pass", DW'(pass), DW'(0));
    chk("midrst_we",   DW'(mem_we), DW'(0));
    chk("midrst_addr", DW'(mem_addr), DW'(0));
    chk("midrst_din",  mem_din, '0);
    chk("midrst_err",  DW'(err_cnt), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_run("after_rst", e);

    // Stuck-at-0 bit 5 at address 17.
    fault_a = 17;
    m0 = 64'h20;
    m1 = '0;
    e = '{pass: 1'b0, errs: 2, faddr: 17, felem: 2, syn: 64'h20};
    do_run("sa0", e);

    // Stuck-at-1 bit 0 at address 63.
    fault_a = 63;
    m0 = '0;
    m1 = 64'h1;
    e = '{pass: 1'b0, errs: 3, faddr: 63, felem: 1, syn: 64'h1};
    do_run("sa1", e);

    // start re-pulsed mid-run and held through DONE.
    fault_a = -1;
    m1 = '0;
    bcnt = 0;
    dcnt = 0;
    pulse_start();
    wait_busy_cycles("restart", 50);
    pulse_start();
    chk("restart_busy_mid", DW'(busy), DW'(1));
    wait_done("restart");
    chk("restart_len", DW'(bcnt), DW'(RUN));
    chk("restart_pass", DW'(pass), DW'(1));
    start = 1'b1;
    @(negedge clk);
    chk("restart_idle_busy", DW'(busy), DW'(0));
    chk("restart_idle_done", DW'(done), DW'(0));
    chk("restart_one_done", DW'(dcnt), DW'(1));
    @(negedge clk);
    start = 1'b0;
    chk("restart_second_busy", DW'(busy), DW'(1));
    chk("restart_pass_cleared", DW'(pass), DW'(0));
    wait_done("second");
    chk("second_pass", DW'(pass), DW'(1));
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
